hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage Ak-16b core (IF/ID/EX/MEM/WB).
- Consumes the registered decoder outputs (reg_write, mem_read, mem_write, branch/jump, halt) as they travel down the pipe.
- Produces the `stall` input the decoder consumes, plus pipeline-register enables, flushes, forwarding selects and halt sequencing.

Parameters:
- RA_W, 4, register-address width (16 architectural registers; r0 reads zero).
- DRAIN_CYC, 3, cycles to drain EX/MEM/WB after HALT leaves ID.
- CNT_W, 16, width of stall-cycle statistic counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RA_W each  ID source regs
- id_use_rs, id_use_rt  in  1 each  ID reads rs/rt
- id_halt  in  1  decoder halt for ID instruction
- ex_valid, ex_reg_write, ex_mem_read  in  1 each  EX-stage controls
- ex_rd, ex_rs, ex_rt  in  RA_W each  EX regs
- ex_redirect  in  1  EX resolved taken branch/BNE or jump
- mem_valid, mem_reg_write, mem_mem_read, mem_mem_write  in  1 each  MEM-stage controls
- mem_rd  in  RA_W  MEM dest
- mem_ready  in  1  data-memory handshake complete
- wb_valid, wb_reg_write  in  1 each  WB controls
- wb_rd  in  RA_W  WB dest
- stall  out  1  to decoder; freezes PC
- if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline-register load enables
- flush_if_id, flush_id_ex  out  1 each  insert bubble (clear valid)
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 MEM-stage ALU result, 10 WB result
- halted  out  1  core stopped
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- FSM states: RUN, DRAIN, HALTED. Reset → RUN, drain counter = 0, stall_cnt = 0.
- Reset output values: stall=0, all enables=1, flushes=0, fwd=00, halted=0.
- mem_busy = mem_valid & (mem_mem_read | mem_mem_write) & !mem_ready.
- load_use = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
- RUN, per-cycle priority (highest first):
  1. mem_busy: stall=1, if_id_en=id_ex_en=ex_mem_en=0, no flushes; holds until mem_ready.
  2. ex_redirect: stall=0 (PC loads target), flush_if_id=1, flush_id_ex=1. Any id_halt in the same cycle is squashed; no DRAIN.
  3. load_use: stall=1, if_id_en=0, flush_id_ex=1; exactly one bubble per load-use pair.
  4. id_valid & id_halt: next state DRAIN, counter=DRAIN_CYC, stall=1.
- DRAIN:
  - stall=1, if_id_en=0, flush_id_ex=1 every cycle.
  - Counter decrements only when !mem_busy; mem_busy still freezes the later stages.
  - Counter reaching 0 → HALTED.
- HALTED: stall=1, all enables=0, halted=1. Only rst exits.
- Forwarding (combinational, all states):
  - fwd_a=01 if mem_valid & mem_reg_write & !mem_mem_read & mem_rd≠0 & mem_rd==ex_rs.
  - Else fwd_a=10 if wb_valid & wb_reg_write & wb_rd≠0 & wb_rd==ex_rs.
  - Else fwd_a=00. MEM has priority over WB. fwd_b is identical using ex_rt.
- r0 never causes a hazard or forward.
- stall_cnt: +1 each cycle stall=1 and state≠HALTED; saturates at all-ones.
- rst mid-DRAIN or mid-mem_busy: next cycle is RUN with reset outputs, independent of other inputs.
- All outputs other than halted and stall_cnt are combinational from state and inputs. halted and stall_cnt are registered.

Decomposition:
- Shared def package: state encodings (HZ_RUN/HZ_DRAIN/HZ_HALTED) and forward-select constants (FWD_RF=00, FWD_MEM=01, FWD_WB=10), alongside the existing opcode/ALU defines.
- One sub-module, fwd_unit: pure combinational forwarding compare, instantiated once per operand (A, B).

Test Plan:
- LW r3 in EX (ex_mem_read=1, ex_rd=3), ID ADD reading rs=3 → one cycle stall=1, if_id_en=0, flush_id_ex=1. Next cycle stall=0. stall_cnt=1.
- Same as above with ex_rd=0 → no stall; fwd stays 00.
- mem_valid & mem_mem_read with mem_ready low for 4 cycles → stall=1 and all enables=0 for 4 cycles. Release on mem_ready=1. stall_cnt=4.
- ex_redirect=1 with id_halt=1 in the same cycle → flush_if_id=flush_id_ex=1, stall=0. State stays RUN; halted stays 0.
- id_halt alone → 3 DRAIN cycles (stall=1), then halted=1 on the 4th cycle and held for 10 cycles. rst=1 → halted=0, stall=0, stall_cnt=0.
- mem_rd=ex_rs=5 with mem_reg_write, and wb_rd=5 with wb_reg_write → fwd_a=01. Drop the MEM match → fwd_a=10. Set mem_mem_read=1 with MEM match only → fwd_a=00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the Ak-16b hazard controller: FSM state encodings
// and EX operand forward-select codes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'b00,
    HZ_DRAIN  = 2'b01,
    HZ_HALTED = 2'b10
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_MEM = 2'b01;
  localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle between the Ak-16b stage registers and the hazard
// controller; the controller is the slave, the pipeline (or a bench) the master.
interface hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) ();

  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_halt;
  logic            ex_valid;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [RA_W-1:0] ex_rd;
  logic [RA_W-1:0] ex_rs;
  logic [RA_W-1:0] ex_rt;
  logic            ex_redirect;
  logic            mem_valid;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;
  logic [RA_W-1:0] mem_rd;
  logic            mem_ready;
  logic            wb_valid;
  logic            wb_reg_write;
  logic [RA_W-1:0] wb_rd;

  logic             stall;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
    output ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_rs, ex_rt, ex_redirect,
    output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, mem_ready,
    output wb_valid, wb_reg_write, wb_rd,
    input  stall, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex,
    input  fwd_a, fwd_b, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_halt,
    input  ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_rs, ex_rt, ex_redirect,
    input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_rd, mem_ready,
    input  wb_valid, wb_reg_write, wb_rd,
    output stall, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex,
    output fwd_a, fwd_b, halted, stall_cnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding compare for one EX source operand: MEM-stage ALU result beats
// WB result; loads in MEM are excluded because their data is not ready yet.
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] ex_src,
  input  logic            mem_valid,
  input  logic            mem_reg_write,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            wb_valid,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  output fwd_sel_t        fwd_sel
);

  logic mem_hit_s;
  logic wb_hit_s;

  assign mem_hit_s = mem_valid & mem_reg_write & ~mem_mem_read &
                     (mem_rd != {RA_W{1'b0}}) & (mem_rd == ex_src);
  assign wb_hit_s  = wb_valid & wb_reg_write &
                     (wb_rd != {RA_W{1'b0}}) & (wb_rd == ex_src);

  // Priority select of the youngest producing stage
  always_comb begin
    fwd_sel = FWD_RF;
    if (mem_hit_s) begin
      fwd_sel = FWD_MEM;
    end else if (wb_hit_s) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage Ak-16b core: memory-wait
// freeze, redirect flush, load-use bubble, halt drain and operand forwarding.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int RA_W      = 4,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave pipe
);

  localparam int DC_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYC);
  localparam logic [DC_W-1:0]  DC_ONE     = DC_W'(32'd1);
  localparam logic [DC_W-1:0]  DC_ZERO    = {DC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  hz_state_t        state_r;
  hz_state_t        state_nx_s;
  logic [DC_W-1:0]  drain_cnt_r;
  logic [DC_W-1:0]  drain_cnt_nx_s;
  logic             halted_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic     mem_busy_s;
  logic     load_use_s;
  logic     stall_s;
  logic     if_id_en_s;
  logic     id_ex_en_s;
  logic     ex_mem_en_s;
  logic     flush_if_id_s;
  logic     flush_id_ex_s;
  fwd_sel_t fwd_a_s;
  fwd_sel_t fwd_b_s;

  assign mem_busy_s = pipe.mem_valid & (pipe.mem_mem_read | pipe.mem_mem_write) &
                      ~pipe.mem_ready;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use_s = pipe.ex_valid & pipe.ex_mem_read &
                      (pipe.ex_rd != {RA_W{1'b0}}) & pipe.id_valid &
                      ((pipe.id_use_rs & (pipe.id_rs == pipe.ex_rd)) |
                       (pipe.id_use_rt & (pipe.id_rt == pipe.ex_rd)));

  // Next-state and pipeline control decode
  always_comb begin
    state_nx_s     = state_r;
    drain_cnt_nx_s = drain_cnt_r;
    stall_s        = 1'b0;
    if_id_en_s     = 1'b1;
    id_ex_en_s     = 1'b1;
    ex_mem_en_s    = 1'b1;
    flush_if_id_s  = 1'b0;
    flush_id_ex_s  = 1'b0;
    case (state_r)
      HZ_RUN: begin
        if (mem_busy_s) begin
          stall_s     = 1'b1;
          if_id_en_s  = 1'b0;
          id_ex_en_s  = 1'b0;
          ex_mem_en_s = 1'b0;
        end else if (pipe.ex_redirect) begin
          // PC takes the branch target; a halt decoded on the wrong path dies here
          flush_if_id_s = 1'b1;
          flush_id_ex_s = 1'b1;
        end else if (load_use_s) begin
          stall_s       = 1'b1;
          if_id_en_s    = 1'b0;
          flush_id_ex_s = 1'b1;
        end else if (pipe.id_valid & pipe.id_halt) begin
          stall_s        = 1'b1;
          if_id_en_s     = 1'b0;
          state_nx_s     = HZ_DRAIN;
          drain_cnt_nx_s = DRAIN_LOAD;
        end else begin
          state_nx_s = HZ_RUN;
        end
      end
      HZ_DRAIN: begin
        stall_s       = 1'b1;
        if_id_en_s    = 1'b0;
        flush_id_ex_s = 1'b1;
        if (mem_busy_s) begin
          id_ex_en_s  = 1'b0;
          ex_mem_en_s = 1'b0;
        end else if (drain_cnt_r <= DC_ONE) begin
          state_nx_s     = HZ_HALTED;
          drain_cnt_nx_s = DC_ZERO;
        end else begin
          drain_cnt_nx_s = drain_cnt_r - DC_ONE;
        end
      end
      HZ_HALTED: begin
        stall_s     = 1'b1;
        if_id_en_s  = 1'b0;
        id_ex_en_s  = 1'b0;
        ex_mem_en_s = 1'b0;
      end
      default: begin
        state_nx_s     = HZ_RUN;
        drain_cnt_nx_s = DC_ZERO;
      end
    endcase
  end

  // State, drain counter, halted flag and saturating stall statistic
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= HZ_RUN;
      drain_cnt_r <= DC_ZERO;
      halted_r    <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      drain_cnt_r <= drain_cnt_nx_s;
      halted_r    <= (state_nx_s == HZ_HALTED);
      if (stall_s && (state_r != HZ_HALTED) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  hazard_ctrl_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .ex_src        (pipe.ex_rs),
    .mem_valid     (pipe.mem_valid),
    .mem_reg_write (pipe.mem_reg_write),
    .mem_mem_read  (pipe.mem_mem_read),
    .mem_rd        (pipe.mem_rd),
    .wb_valid      (pipe.wb_valid),
    .wb_reg_write  (pipe.wb_reg_write),
    .wb_rd         (pipe.wb_rd),
    .fwd_sel       (fwd_a_s)
  );

  hazard_ctrl_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .ex_src        (pipe.ex_rt),
    .mem_valid     (pipe.mem_valid),
    .mem_reg_write (pipe.mem_reg_write),
    .mem_mem_read  (pipe.mem_mem_read),
    .mem_rd        (pipe.mem_rd),
    .wb_valid      (pipe.wb_valid),
    .wb_reg_write  (pipe.wb_reg_write),
    .wb_rd         (pipe.wb_rd),
    .fwd_sel       (fwd_b_s)
  );

  assign pipe.stall       = stall_s;
  assign pipe.if_id_en    = if_id_en_s;
  assign pipe.id_ex_en    = id_ex_en_s;
  assign pipe.ex_mem_en   = ex_mem_en_s;
  assign pipe.flush_if_id = flush_if_id_s;
  assign pipe.flush_id_ex = flush_id_ex_s;
  assign pipe.fwd_a       = fwd_a_s;
  assign pipe.fwd_b       = fwd_b_s;
  assign pipe.halted      = halted_r;
  assign pipe.stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: load-use, memory wait,
// redirect, halt drain, forwarding priority, reset and counter saturation.
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hazard_ctrl_if #(.RA_W(4), .CNT_W(16)) pipe ();

  hazard_ctrl #(.RA_W(4), .DRAIN_CYC(3), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .pipe (pipe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex}
  function automatic logic [5:0] ctl();
    return {pipe.stall, pipe.if_id_en, pipe.id_ex_en, pipe.ex_mem_en,
            pipe.flush_if_id, pipe.flush_id_ex};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pipe.id_valid = 1'b0; pipe.id_rs = 4'd0; pipe.id_rt = 4'd0;
    pipe.id_use_rs = 1'b0; pipe.id_use_rt = 1'b0; pipe.id_halt = 1'b0;
    pipe.ex_valid = 1'b0; pipe.ex_reg_write = 1'b0; pipe.ex_mem_read = 1'b0;
    pipe.ex_rd = 4'd0; pipe.ex_rs = 4'd0; pipe.ex_rt = 4'd0; pipe.ex_redirect = 1'b0;
    pipe.mem_valid = 1'b0; pipe.mem_reg_write = 1'b0; pipe.mem_mem_read = 1'b0;
    pipe.mem_mem_write = 1'b0; pipe.mem_rd = 4'd0; pipe.mem_ready = 1'b1;
    pipe.wb_valid = 1'b0; pipe.wb_reg_write = 1'b0; pipe.wb_rd = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle();
    tick();
    tick();
    settle();
    check("rst_ctl", 32'(ctl()), 32'h1C);
    check("rst_fwd", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h0);
    check("rst_halted", 32'(pipe.halted), 32'h0);
    check("rst_cnt", 32'(pipe.stall_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // LW r3 in EX, ADD reading r3 in ID
    pipe.ex_valid = 1'b1; pipe.ex_mem_read = 1'b1; pipe.ex_reg_write = 1'b1; pipe.ex_rd = 4'd3;
    pipe.id_valid = 1'b1; pipe.id_use_rs = 1'b1; pipe.id_rs = 4'd3;
    settle();
    check("lu_ctl", 32'(ctl()), 32'h2D);
    tick();
    idle();
    pipe.mem_valid = 1'b1; pipe.mem_mem_read = 1'b1; pipe.mem_reg_write = 1'b1; pipe.mem_rd = 4'd3;
    pipe.id_valid = 1'b1; pipe.id_use_rs = 1'b1; pipe.id_rs = 4'd3;
    settle();
    check("lu_release", 32'(ctl()), 32'h1C);
    tick();
    check("lu_cnt", 32'(pipe.stall_cnt), 32'd1);

    // Load to r0 is not a hazard
    idle();
    pipe.ex_valid = 1'b1; pipe.ex_mem_read = 1'b1; pipe.ex_rd = 4'd0;
    pipe.id_valid = 1'b1; pipe.id_use_rs = 1'b1; pipe.id_rs = 4'd0;
    settle();
    check("r0_ctl", 32'(ctl()), 32'h1C);
    check("r0_fwd", 32'(pipe.fwd_a), 32'h0);
    // rt-side match with rs unused but matching does not matter
    pipe.ex_rd = 4'd4; pipe.id_use_rs = 1'b0; pipe.id_rs = 4'd4; pipe.id_rt = 4'd9; pipe.id_use_rt = 1'b1;
    settle();
    check("lu_unused_rs", 32'(ctl()), 32'h1C);
    pipe.id_rt = 4'd4;
    settle();
    check("lu_rt", 32'(ctl()), 32'h2D);
    tick();
    check("lu_rt_cnt", 32'(pipe.stall_cnt), 32'd2);

    // Data memory wait for four cycles, redirect present but outranked
    idle();
    pipe.mem_valid = 1'b1; pipe.mem_mem_read = 1'b1; pipe.mem_ready = 1'b0;
    pipe.ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("busy_ctl", 32'(ctl()), 32'h20);
      tick();
      pipe.ex_redirect = 1'b0;
    end
    pipe.mem_ready = 1'b1;
    settle();
    check("busy_release", 32'(ctl()), 32'h1C);
    tick();
    check("busy_cnt", 32'(pipe.stall_cnt), 32'd6);

    // Redirect squashes a halt in ID
    idle();
    pipe.ex_redirect = 1'b1; pipe.id_valid = 1'b1; pipe.id_halt = 1'b1;
    settle();
    check("redir_ctl", 32'(ctl()), 32'h1F);
    tick();
    idle();
    settle();
    check("redir_run", 32'(ctl()), 32'h1C);
    check("redir_halted", 32'(pipe.halted), 32'h0);
    check("redir_cnt", 32'(pipe.stall_cnt), 32'd6);

    // Forwarding priority and r0
    idle();
    pipe.ex_rs = 4'd5; pipe.ex_rt = 4'd9;
    pipe.mem_valid = 1'b1; pipe.mem_reg_write = 1'b1; pipe.mem_rd = 4'd5;
    pipe.wb_valid = 1'b1; pipe.wb_reg_write = 1'b1; pipe.wb_rd = 4'd5;
    settle();
    check("fwd_mem_wins", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h4);
    pipe.mem_rd = 4'd6;
    settle();
    check("fwd_wb", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h8);
    pipe.mem_rd = 4'd5; pipe.mem_mem_read = 1'b1; pipe.wb_rd = 4'd4;
    settle();
    check("fwd_load_no", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h0);
    pipe.mem_mem_read = 1'b0; pipe.mem_rd = 4'd9; pipe.wb_rd = 4'd5;
    settle();
    check("fwd_b_mem", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h9);
    pipe.ex_rs = 4'd0; pipe.ex_rt = 4'd0; pipe.mem_rd = 4'd0; pipe.wb_rd = 4'd0;
    settle();
    check("fwd_r0", 32'({pipe.fwd_a, pipe.fwd_b}), 32'h0);
    pipe.wb_reg_write = 1'b0; pipe.ex_rs = 4'd7; pipe.wb_rd = 4'd7;
    settle();
    check("fwd_wb_nowrite", 32'(pipe.fwd_a), 32'h0);
    tick();

    // Halt: RUN cycle, DRAIN 3 / mem-wait / 2 / 1, then HALTED
    idle();
    pipe.id_valid = 1'b1; pipe.id_halt = 1'b1;
    settle();
    check("halt_ctl", 32'(ctl()), 32'h2C);
    tick();
    idle();
    settle();
    check("drain1_ctl", 32'(ctl()), 32'h2D);
    check("drain1_halted", 32'(pipe.halted), 32'h0);
    tick();
    pipe.mem_valid = 1'b1; pipe.mem_mem_write = 1'b1; pipe.mem_ready = 1'b0;
    settle();
    check("drain_busy_ctl", 32'(ctl()), 32'h21);
    tick();
    idle();
    settle();
    check("drain2_ctl", 32'(ctl()), 32'h2D);
    tick();
    settle();
    check("drain3_ctl", 32'(ctl()), 32'h2D);
    check("drain3_halted", 32'(pipe.halted), 32'h0);
    tick();
    check("halted_ctl", 32'(ctl()), 32'h20);
    check("halted_flag", 32'(pipe.halted), 32'h1);
    check("halted_cnt", 32'(pipe.stall_cnt), 32'd11);
    pipe.ex_redirect = 1'b1; pipe.id_valid = 1'b1; pipe.id_halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted_hold", 32'({pipe.halted, ctl()}), 32'h60);
    end
    check("halted_cnt_frozen", 32'(pipe.stall_cnt), 32'd11);

    // Reset leaves HALTED
    idle();
    rst = 1'b1;
    tick();
    settle();
    check("rst_exit_ctl", 32'(ctl()), 32'h1C);
    check("rst_exit_halted", 32'(pipe.halted), 32'h0);
    check("rst_exit_cnt", 32'(pipe.stall_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a drain under memory wait
    pipe.id_valid = 1'b1; pipe.id_halt = 1'b1;
    tick();
    idle();
    pipe.mem_valid = 1'b1; pipe.mem_mem_read = 1'b1; pipe.mem_ready = 1'b0;
    settle();
    check("mid_drain_ctl", 32'(ctl()), 32'h21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    settle();
    check("mid_drain_rst_ctl", 32'(ctl()), 32'h1C);
    check("mid_drain_rst_cnt", 32'(pipe.stall_cnt), 32'h0);

    // Saturation of the stall statistic
    pipe.mem_valid = 1'b1; pipe.mem_mem_read = 1'b1; pipe.mem_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    check("cnt_saturate", 32'(pipe.stall_cnt), 32'hFFFF);
    idle();
    tick();
    check("cnt_sat_hold", 32'(pipe.stall_cnt), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
